// File: rtl/pwm_pkg.sv
// pwm_pkg -- shared constants and helpers for the PWM step array.
//   DEF_*     : default parameter values used by pwm_step_array / btn_debounce
//   duty_w()  : bit width needed to hold a duty value 0..period
//   duty_act_e: per-channel duty update selected in a given cycle
package pwm_pkg;

  localparam int DEF_PERIOD     = 100;
  localparam int DEF_STEP       = 25;
  localparam int DEF_PRESC_DIV  = 67500;
  localparam int DEF_DEB_CYCLES = 4096;

  // Duty spans 0..period inclusive, so one more code than the phase range.
  function automatic int duty_w(input int period);
    return $clog2(period + 1);
  endfunction

  typedef enum logic [1:0] {
    ACT_HOLD,
    ACT_INC,
    ACT_DEC
  } duty_act_e;

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce -- synchroniser, debouncer and press detector for one
// active-low push button.
//   clk   : system clock (rising edge)
//   rst_n : asynchronous active-low reset
//   btn   : raw asynchronous button, 0 = pressed
//   press : one-cycle pulse on an accepted released->pressed transition
module btn_debounce
  import pwm_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          armed;
  logic [CW-1:0] cnt;

  // The synchroniser clears to "pressed" and presses are only reported once
  // a released sample has been seen (armed). A button held through reset
  // therefore produces no event until it is released and pressed again,
  // while the debounced level itself starts at released.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the values from before the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b1;
      armed <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2) armed <= 1'b1;
      // Count cycles the synchronised input disagrees with the accepted
      // level; any agreement (a bounce back) restarts the count.
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        level <= sync2;
        press <= ~sync2 & armed;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pwm_step_array.sv
// pwm_step_array -- CHANNELS independent PWM outputs sharing one prescaler
// and phase counter; each channel's duty is stepped by its own inc/dec
// buttons.
//   clk     : system clock (rising edge)
//   rst_n   : asynchronous active-low reset
//   btn_inc : per-channel increment buttons, active-low, asynchronous
//   btn_dec : per-channel decrement buttons, active-low, asynchronous
//   pwm     : registered PWM outputs
//   duty    : pending duty per channel, channel i at [i*W +: W]
module pwm_step_array
  import pwm_pkg::*;
#(
  parameter int CHANNELS   = 4,
  parameter int PRESC_DIV  = DEF_PRESC_DIV,
  parameter int PERIOD     = DEF_PERIOD,
  parameter int STEP       = DEF_STEP,
  parameter int DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int SATURATE   = 0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [CHANNELS-1:0]              btn_inc,
  input  logic [CHANNELS-1:0]              btn_dec,
  output logic [CHANNELS-1:0]              pwm,
  output logic [CHANNELS*duty_w(PERIOD)-1:0] duty
);

  localparam int W   = duty_w(PERIOD);
  localparam int PCW = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
  localparam logic [PCW-1:0] PRESC_LAST = PCW'(PRESC_DIV - 1);
  localparam logic [W-1:0]   PHASE_LAST = W'(PERIOD - 1);
  localparam logic [W-1:0]   PERIOD_V   = W'(PERIOD);
  localparam logic [W-1:0]   STEP_V     = W'(STEP);
  localparam logic [W:0]     PERIOD_X   = (W+1)'(PERIOD);
  localparam logic [W:0]     STEP_X     = (W+1)'(STEP);

  logic [PCW-1:0]      presc_cnt;
  logic                tick;
  logic [W-1:0]        phase;
  logic                period_end;
  logic [CHANNELS-1:0] inc_ev;
  logic [CHANNELS-1:0] dec_ev;

  // Counter clears on reset, so the first tick after reset comes a full
  // PRESC_DIV cycles later.
  assign tick       = (presc_cnt == PRESC_LAST);
  assign period_end = tick && (phase == PHASE_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_cnt <= '0;
      phase     <= '0;
    end else begin
      presc_cnt <= tick ? '0 : presc_cnt + 1'b1;
      if (tick) phase <= period_end ? '0 : phase + 1'b1;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [W-1:0] duty_q;
    logic [W-1:0] duty_nxt;
    logic [W-1:0] active_q;
    logic [W:0]   sum;
    logic         pwm_q;
    duty_act_e    act;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_inc (
      .clk   (clk),
      .rst_n (rst_n),
      .btn   (btn_inc[i]),
      .press (inc_ev[i])
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_dec (
      .clk   (clk),
      .rst_n (rst_n),
      .btn   (btn_dec[i]),
      .press (dec_ev[i])
    );

    // NOTE: every signal gets a default before any branch so the block is
    // purely combinational and infers no latch.
    always_comb begin
      act      = ACT_HOLD;
      duty_nxt = duty_q;
      sum      = {1'b0, duty_q} + STEP_X;
      // Coincident inc and dec cancel each other.
      if (inc_ev[i] && !dec_ev[i])      act = ACT_INC;
      else if (dec_ev[i] && !inc_ev[i]) act = ACT_DEC;
      case (act)
        ACT_INC: begin
          if (sum > PERIOD_X) duty_nxt = (SATURATE != 0) ? PERIOD_V : '0;
          else                duty_nxt = sum[W-1:0];
        end
        ACT_DEC: begin
          if ({1'b0, duty_q} < STEP_X) duty_nxt = (SATURATE != 0) ? '0 : PERIOD_V;
          else                         duty_nxt = duty_q - STEP_V;
        end
        default: ;
      endcase
    end

    // active only follows duty at the period boundary, so a duty change
    // never reshapes the period already in progress.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        duty_q   <= '0;
        active_q <= '0;
        pwm_q    <= 1'b0;
      end else begin
        duty_q <= duty_nxt;
        if (period_end) active_q <= duty_q;
        pwm_q <= (phase < active_q);
      end
    end

    assign pwm[i]         = pwm_q;
    assign duty[i*W +: W] = duty_q;
  end

endmodule

// File: doc/pwm_step_array.md
PWM_STEP_ARRAY -- requirements
Module: pwm_step_array

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, number of independent PWM channels.
REQ-002 SHALL have parameter PRESC_DIV, default 67500, clk cycles per PWM tick (>=1).
REQ-003 SHALL have parameter PERIOD, default 100, PWM ticks per PWM period (>=2).
REQ-004 SHALL have parameter STEP, default 25, duty change per accepted press (1..PERIOD).
REQ-005 SHALL have parameter DEB_CYCLES, default 4096, consecutive stable clk cycles needed to accept a button level.
REQ-006 SHALL have parameter SATURATE, default 0; 0 = wrap mode, 1 = clamp mode.
REQ-007 SHALL have port clk, input, 1, sole clock; all logic is rising-edge.
REQ-008 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port btn_inc, input, CHANNELS, per-channel increment button, active-low, asynchronous.
REQ-010 SHALL have port btn_dec, input, CHANNELS, per-channel decrement button, active-low, asynchronous.
REQ-011 SHALL have port pwm, output, CHANNELS, registered PWM outputs.
REQ-012 SHALL have port duty, output, CHANNELS*W (W = clog2(PERIOD+1)), pending duty per channel, channel i at bits [i*W +: W].

Function
REQ-013 SHALL pass each button through a 2-flop synchroniser before any other use.
REQ-014 SHALL accept a new debounced level only after DEB_CYCLES consecutive cycles of a stable synchronised level; a bounce restarts the count.
REQ-015 SHALL raise a one-cycle press event on a debounced 1->0 transition; releases raise no event.
REQ-016 SHALL, on an inc event, set duty to duty+STEP; if the sum exceeds PERIOD: 0 in wrap mode, PERIOD in clamp mode.
REQ-017 SHALL, on a dec event, set duty to duty-STEP; if duty<STEP: PERIOD in wrap mode, 0 in clamp mode.
REQ-018 SHALL ignore both events when inc and dec events on one channel fall in the same cycle.
REQ-019 SHALL update duty in the cycle after the press event; channels are fully independent.
REQ-020 SHALL have the prescaler emit a one-cycle tick every PRESC_DIV clk cycles; PRESC_DIV=1 means a tick every cycle.
REQ-021 SHALL advance a shared phase counter 0..PERIOD-1 on each tick, wrapping PERIOD-1 -> 0.
REQ-022 SHALL copy duty into a per-channel active register on the tick where phase wraps to 0; duty changes never alter the current period.
REQ-023 SHALL register pwm[i] = (phase < active[i]): active=0 gives constant low, active=PERIOD gives constant high.
REQ-024 SHALL make pwm lag its phase value by exactly one clk cycle.

Reset
REQ-025 SHALL on rst_n low asynchronously clear pwm, duty, active, phase, prescaler and debounce counters to 0.
REQ-026 SHALL set the debounced levels to 1 (released) on reset, so a button held through reset yields no event until it is released and pressed again.
REQ-027 SHALL, after rst_n is released mid-period, start with phase 0 and a full PRESC_DIV count before the first tick.

Structure
REQ-028 SHALL place the defaults for PERIOD, STEP, PRESC_DIV and DEB_CYCLES, and the width function W, in a shared pwm_pkg constants file.
REQ-029 SHALL implement the synchroniser, debounce and press event in a sub-module btn_debounce, instantiated 2*CHANNELS times.
REQ-030 SHALL place the prescaler, phase counter and duty and active registers in pwm_step_array itself.

Verification
Benches use PRESC_DIV=1, DEB_CYCLES=4, CHANNELS=2.
REQ-031 SHALL cover: ch0 btn_inc pressed 5 times, wrap mode -> duty0 goes 25,50,75,100,0; duty1 stays 0.
REQ-032 SHALL cover: clamp mode, 5 inc then 6 dec -> duty saturates at 100, then falls to 0 and stays 0.
REQ-033 SHALL cover: btn_inc toggling every 2 cycles for 20 cycles, then held low -> exactly one event, duty=25.
REQ-034 SHALL cover: duty 50 -> 75 at phase 30 -> pwm high for 50 ticks in the current period, 75 in the next.
REQ-035 SHALL cover: simultaneous inc and dec events on ch1 -> duty1 unchanged; ch0 inc in the same cycle -> applied.
REQ-036 SHALL cover: rst_n pulsed low mid-period with btn held -> all outputs 0 immediately, no event until the button is released and re-pressed.
